inst_mmu: RTL and testbench

INST_MMU -- requirements
Module: inst_mmu

---
 rtl/inst_mmu_pkg.sv | 18 +
 rtl/inst_req_fifo.sv | 75 +++++++
 rtl/inst_mmu.sv | 91 +++++++++
 tb/tb_inst_mmu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mmu_pkg.sv
// Shared constants and types for the instruction-fetch memory unit.
// Holds the NOP word, the default outstanding-read depth and the tracker entry layout.
package inst_mmu_pkg;

    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 4;

    // One outstanding read: the original fetch address plus a flag set when a flush orphans it.
    typedef struct packed {
        logic        stale;
        logic [31:0] addr;
    } req_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_req_fifo.sv
// Outstanding-read tracker: in-order FIFO of {stale, addr} entries.
// mark_stale tags every live entry, including one being written in the same cycle.
module inst_req_fifo
    import inst_mmu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [31:0]      push_addr,
    input  logic             pop,
    input  logic             mark_stale,
    output req_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [31:0]      addr_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] stale_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head.stale = stale_q[rd_ptr];
    assign head.addr  = addr_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            stale_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mark_stale && valid_q[i]) begin
                    stale_q[i] <= 1'b1;
                end
            end
            if (pop_ok) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            // Later assignment wins, so a new entry picks up the flush tag directly.
            if (push_ok) begin
                valid_q[wr_ptr] <= 1'b1;
                stale_q[wr_ptr] <= mark_stale;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/inst_mmu.sv
// Instruction-fetch bridge: turns fetch requests into bus reads and returns words in order.
// Handshakes: a bus beat transfers when valid && ready on a rising CLK edge; valid never drops before that.
module inst_mmu
    import inst_mmu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    output logic        MEM_WAIT,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    output logic        MEM_ARVALID,
    input  logic        MEM_ARREADY,
    output logic [31:0] MEM_ARADDR,
    input  logic        MEM_RVALID,
    output logic        MEM_RREADY,
    input  logic [31:0] MEM_RDATA,
    output logic        ERR
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] req_count;
    req_entry_t       head;

    assign MEM_RREADY = 1'b1;
    assign MEM_WAIT   = (MEM_ARVALID && !MEM_ARREADY) || fifo_full;
    assign accept     = INST_RDEN && !MEM_WAIT && !FLUSH;
    assign pop        = MEM_RVALID && !fifo_empty;

    inst_req_fifo #(
        .DEPTH(DEPTH)
    ) u_req_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (accept),
        .push_addr  (INST_RIADDR),
        .pop        (pop),
        .mark_stale (FLUSH),
        .head       (head),
        .count      (req_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Read-address channel; accept is only possible when the slot is empty or handshaking now.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_ARVALID <= 1'b0;
            MEM_ARADDR  <= '0;
        end else if (accept) begin
            MEM_ARVALID <= 1'b1;
            MEM_ARADDR  <= align_word(INST_RIADDR);
        end else if (MEM_ARREADY) begin
            MEM_ARVALID <= 1'b0;
        end
    end

    // A word popped in a flush cycle is discarded just like an already-stale one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            INST_RVALID <= 1'b0;
            INST_ROADDR <= '0;
            INST_RDATA  <= NOP_INSN;
        end else begin
            INST_RVALID <= pop && !head.stale && !FLUSH;
            if (pop && !head.stale && !FLUSH) begin
                INST_ROADDR <= head.addr;
                INST_RDATA  <= MEM_RDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (MEM_RVALID && fifo_empty) begin
            ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_mmu.sv
// Directed bench for inst_mmu: a hand-driven bus slave and hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_inst_mmu;

    logic        CLK;
    logic        RST;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic        INST_RVALID;
    logic [31:0] INST_ROADDR;
    logic [31:0] INST_RDATA;
    logic        MEM_ARVALID;
    logic        MEM_ARREADY;
    logic [31:0] MEM_ARADDR;
    logic        MEM_RVALID;
    logic        MEM_RREADY;
    logic [31:0] MEM_RDATA;
    logic        ERR;

    int n_total = 0;
    int n_pass  = 0;

    inst_mmu #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FLUSH       (FLUSH),
        .MEM_WAIT    (MEM_WAIT),
        .INST_RDEN   (INST_RDEN),
        .INST_RIADDR (INST_RIADDR),
        .INST_RVALID (INST_RVALID),
        .INST_ROADDR (INST_ROADDR),
        .INST_RDATA  (INST_RDATA),
        .MEM_ARVALID (MEM_ARVALID),
        .MEM_ARREADY (MEM_ARREADY),
        .MEM_ARADDR  (MEM_ARADDR),
        .MEM_RVALID  (MEM_RVALID),
        .MEM_RREADY  (MEM_RREADY),
        .MEM_RDATA   (MEM_RDATA),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rden, input logic [31:0] addr, input logic arready,
                         input logic rvalid, input logic [31:0] rdata, input logic flush);
        INST_RDEN   = rden;
        INST_RIADDR = addr;
        MEM_ARREADY = arready;
        MEM_RVALID  = rvalid;
        MEM_RDATA   = rdata;
        FLUSH       = flush;
        #1;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_arvalid", 32'(MEM_ARVALID), 32'd0);
        chk("rst_araddr",  MEM_ARADDR, 32'h0);
        chk("rst_rvalid",  32'(INST_RVALID), 32'd0);
        chk("rst_roaddr",  INST_ROADDR, 32'h0);
        chk("rst_rdata",   INST_RDATA, 32'h0000_0013);
        chk("rst_err",     32'(ERR), 32'd0);
        chk("rst_rready",  32'(MEM_RREADY), 32'd1);
        chk("rst_wait",    32'(MEM_WAIT), 32'd0);
        chk("rst_count",   32'(dut.req_count), 32'd0);
        RST = 1'b0;

        // Four streamed fetches, each read answered two cycles after its AR handshake
        for (int c = 0; c < 9; c++) begin
            drive(c < 4, 32'h2000_0000 + 32'(4 * c), 1'b1,
                  (c >= 3 && c <= 6), 32'hA000_0000 + 32'(c - 3), 1'b0);
            chk("t1_wait", 32'(MEM_WAIT), 32'd0);
            chk("t1_arvalid", 32'(MEM_ARVALID), 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk("t1_araddr", MEM_ARADDR, 32'h2000_0000 + 32'(4 * (c - 1)));
            tick();
            chk("t1_rvalid", 32'(INST_RVALID), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk("t1_roaddr", INST_ROADDR, 32'h2000_0000 + 32'(4 * (c - 3)));
                chk("t1_rdata",  INST_RDATA, 32'hA000_0000 + 32'(c - 3));
            end
        end
        chk("t1_count_end", 32'(dut.req_count), 32'd0);

        // Fill to DEPTH, stall AR, then free one slot with a single response
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, (e == 0) ? 32'h3000_0002 : 32'h3000_0000 + 32'(4 * e),
                  1'b1, 1'b0, 32'h0, 1'b0);
            chk("t2_fill_wait", 32'(MEM_WAIT), 32'd0);
            tick();
            if (e == 0) chk("t2_aligned_araddr", MEM_ARADDR, 32'h3000_0000);
        end
        drive(1'b1, 32'h3000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_wait_full", 32'(MEM_WAIT), 32'd1);
        chk("t2_count_full", 32'(dut.req_count), 32'd4);
        tick();
        chk("t2_no_fifth_push", 32'(dut.req_count), 32'd4);
        chk("t2_ar_held_valid", 32'(MEM_ARVALID), 32'd1);
        chk("t2_ar_held_addr", MEM_ARADDR, 32'h3000_000C);
        drive(1'b1, 32'h3000_0010, 1'b1, 1'b1, 32'hB000_0000, 1'b0);
        chk("t2_wait_still_full", 32'(MEM_WAIT), 32'd1);
        tick();
        chk("t2_count_after_pop", 32'(dut.req_count), 32'd3);
        chk("t2_rvalid", 32'(INST_RVALID), 32'd1);
        chk("t2_roaddr_unaligned", INST_ROADDR, 32'h3000_0002);
        chk("t2_rdata", INST_RDATA, 32'hB000_0000);
        chk("t2_ar_done", 32'(MEM_ARVALID), 32'd0);
        drive(1'b1, 32'h3000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_wait_released", 32'(MEM_WAIT), 32'd0);
        tick();
        chk("t2_single_push", 32'(dut.req_count), 32'd4);
        chk("t2_new_araddr", MEM_ARADDR, 32'h3000_0010);
        chk("t2_rvalid_gap", 32'(INST_RVALID), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_wait_refull", 32'(MEM_WAIT), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0001 + 32'(i), 1'b0);
            tick();
            chk("t2_drain_rvalid", 32'(INST_RVALID), 32'd1);
            chk("t2_drain_roaddr", INST_ROADDR, 32'h3000_0004 + 32'(4 * i));
            chk("t2_drain_rdata", INST_RDATA, 32'hB000_0001 + 32'(i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t2_count_end", 32'(dut.req_count), 32'd0);

        // Flush with three outstanding; their responses vanish, the next request returns
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 32'h4000_0000 + 32'(4 * f), 1'b1, 1'b0, 32'h0, 1'b0);
            tick();
        end
        chk("t3_count_pre", 32'(dut.req_count), 32'd3);
        drive(1'b1, 32'h4000_000C, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t3_flush_no_accept", 32'(dut.req_count), 32'd3);
        chk("t3_flush_rvalid", 32'(INST_RVALID), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0000, 1'b0);
        tick();
        chk("t3_stale0", 32'(INST_RVALID), 32'd0);
        drive(1'b1, 32'h2000_0100, 1'b1, 1'b1, 32'hC000_0001, 1'b0);
        tick();
        chk("t3_stale1", 32'(INST_RVALID), 32'd0);
        chk("t3_push_pop_count", 32'(dut.req_count), 32'd2);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0002, 1'b0);
        tick();
        chk("t3_stale2", 32'(INST_RVALID), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0003, 1'b0);
        tick();
        chk("t3_new_rvalid", 32'(INST_RVALID), 32'd1);
        chk("t3_new_roaddr", INST_ROADDR, 32'h2000_0100);
        chk("t3_new_rdata", INST_RDATA, 32'hC000_0003);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t3_one_cycle", 32'(INST_RVALID), 32'd0);
        chk("t3_roaddr_hold", INST_ROADDR, 32'h2000_0100);
        chk("t3_rdata_hold", INST_RDATA, 32'hC000_0003);

        // Flush coinciding with a response pop and an AR handshake
        drive(1'b1, 32'h5000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h5000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t4_count_pre", 32'(dut.req_count), 32'd2);
        chk("t4_ar_pending", MEM_ARADDR, 32'h5000_0004);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0000, 1'b1);
        tick();
        chk("t4_popped_dropped", 32'(INST_RVALID), 32'd0);
        chk("t4_count_mid", 32'(dut.req_count), 32'd1);
        chk("t4_ar_not_withdrawn", 32'(MEM_ARVALID), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0001, 1'b0);
        tick();
        chk("t4_handshaken_stale", 32'(INST_RVALID), 32'd0);
        chk("t4_count_end", 32'(dut.req_count), 32'd0);
        chk("t4_roaddr_hold", INST_ROADDR, 32'h2000_0100);

        // Response with nothing outstanding
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hE000_0000, 1'b0);
        tick();
        chk("t5_err_set", 32'(ERR), 32'd1);
        chk("t5_no_rvalid", 32'(INST_RVALID), 32'd0);
        chk("t5_count", 32'(dut.req_count), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("t5_err_sticky", 32'(ERR), 32'd1);

        // Reset with two outstanding, alongside a flush
        drive(1'b1, 32'h6000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h6000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t6_count_pre", 32'(dut.req_count), 32'd2);
        chk("t6_arvalid_pre", 32'(MEM_ARVALID), 32'd1);
        RST = 1'b1;
        drive(1'b1, 32'h6000_0008, 1'b1, 1'b1, 32'hF000_0000, 1'b1);
        tick();
        chk("t6_count", 32'(dut.req_count), 32'd0);
        chk("t6_rdata_nop", INST_RDATA, 32'h0000_0013);
        chk("t6_arvalid", 32'(MEM_ARVALID), 32'd0);
        chk("t6_araddr", MEM_ARADDR, 32'h0);
        chk("t6_roaddr", INST_ROADDR, 32'h0);
        chk("t6_err_clear", 32'(ERR), 32'd0);
        chk("t6_rvalid", 32'(INST_RVALID), 32'd0);
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t6_idle_wait", 32'(MEM_WAIT), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
